// File: rtl/coherent_buf_arbiter_pkg.sv
// Shared definitions for the coherent buffer arbiter: buffer geometry and dump FSM encoding.
package coherent_buf_arbiter_pkg;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StDrain = 2'b10
    } dump_state_e;

endpackage

// File: rtl/coh_dump_fifo.sv
// Two-entry skid buffer between the RAM read-return path and the dump stream.
module coh_dump_fifo
    import coherent_buf_arbiter_pkg::*;
#(
    parameter int unsigned Width = DATA_W
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] data,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [Width-1:0] mem_q [2];
    logic [Width-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             push_en, pop_en;

    assign empty  = (count_q == 2'd0);
    assign full   = (count_q == 2'd2);
    assign count  = count_q;
    assign data   = mem_q[rd_ptr_q];
    // A push into a full buffer is accepted only when the head leaves in the same cycle.
    assign pop_en  = pop & ~empty;
    assign push_en = push & (~full | pop_en);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_en) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_en) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push_en} - {1'b0, pop_en};
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/coherent_buf_arbiter.sv
// Arbitrates a single-port coherent buffer between the sum engine (never stalled) and a
// background dump sequencer that streams a wrapped address range out over valid/ready.
module coherent_buf_arbiter
    import coherent_buf_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              eng_rd,
    input  logic              eng_wr,
    input  logic [ADDR_W-1:0] eng_addr,
    input  logic [DATA_W-1:0] eng_d4wt,
    output logic [DATA_W-1:0] eng_d4rd,
    input  logic              dump_start,
    input  logic [ADDR_W-1:0] dump_addr,
    input  logic [ADDR_W-1:0] dump_len,
    output logic              dump_busy,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] remaining_q, remaining_d;
    logic              busy_q, busy_d;
    logic              in_flight_q, in_flight_d;

    logic       eng_req, issue;
    logic       fifo_pop, fifo_empty, fifo_full;
    logic [1:0] fifo_count;
    logic [2:0] occupancy;
    logic       unused_fifo_full;

    assign eng_req          = eng_rd | eng_wr;
    assign fifo_pop         = ~fifo_empty & dump_ready;
    assign unused_fifo_full = fifo_full;
    // Slots still claimed once this cycle's pop retires; a read only goes out into a free slot.
    assign occupancy = {1'b0, fifo_count} + {2'b00, in_flight_q} - {2'b00, fifo_pop};
    assign issue     = (state_q == StRun) & ~eng_req & (occupancy < 3'd2);

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        remaining_d = remaining_q;
        busy_d      = busy_q;
        in_flight_d = issue;
        unique case (state_q)
            StIdle: begin
                if (dump_start) begin
                    state_d     = StRun;
                    rd_addr_d   = dump_addr;
                    remaining_d = dump_len;
                    busy_d      = 1'b1;
                end
            end
            StRun: begin
                if (issue) begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                    if (remaining_q == '0) begin
                        state_d = StDrain;
                    end else begin
                        remaining_d = remaining_q - ADDR_W'(1);
                    end
                end
            end
            StDrain: begin
                if (fifo_empty && !in_flight_q) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= StIdle;
            rd_addr_q   <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            in_flight_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            in_flight_q <= in_flight_d;
        end
    end

    // Engine owns the port whenever it asks; a write beats a simultaneous read.
    assign ram_cs    = eng_req | issue;
    assign ram_we    = eng_wr;
    assign ram_addr  = eng_req ? eng_addr : rd_addr_q;
    assign ram_wdata = eng_d4wt;
    assign eng_d4rd  = ram_rdata;
    assign dump_busy  = busy_q;
    assign dump_valid = ~fifo_empty;

    coh_dump_fifo #(
        .Width (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst_b (rst_b),
        .push  (in_flight_q),
        .pop   (fifo_pop),
        .wdata (ram_rdata),
        .data  (dump_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_coherent_buf_arbiter.sv
// Scoreboard bench for coherent_buf_arbiter with a behavioural 1-cycle-latency RAM.
module tb_coherent_buf_arbiter;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        eng_rd, eng_wr;
    logic [9:0]  eng_addr;
    logic [31:0] eng_d4wt, eng_d4rd;
    logic        dump_start;
    logic [9:0]  dump_addr, dump_len;
    logic        dump_busy, dump_valid, dump_ready;
    logic [31:0] dump_data;
    logic        ram_cs, ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    logic [31:0] mem [1024];
    logic [31:0] exp_q [$];
    logic [31:0] exp_w;
    int vectors = 0;
    int miscompares = 0;
    int words_rx = 0;
    int dump_reads = 0;

    always #5 clk = ~clk;

    coherent_buf_arbiter #(
        .ADDR_W (10),
        .DATA_W (32)
    ) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .eng_rd     (eng_rd),
        .eng_wr     (eng_wr),
        .eng_addr   (eng_addr),
        .eng_d4wt   (eng_d4wt),
        .eng_d4rd   (eng_d4rd),
        .dump_start (dump_start),
        .dump_addr  (dump_addr),
        .dump_len   (dump_len),
        .dump_busy  (dump_busy),
        .dump_data  (dump_data),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .ram_cs     (ram_cs),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    function automatic logic [31:0] pat(input logic [9:0] a);
        return {6'b101010, a, 6'b010101, ~a};
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] <= pat(10'(i));
    end

    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    // Stream monitor: every handshaken word is checked against the scoreboard head.
    always @(negedge clk) begin
        if (rst_b && dump_valid && dump_ready) begin
            words_rx++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL stream_extra: got %h, want no word", dump_data);
            end else begin
                exp_w = exp_q.pop_front();
                if (dump_data !== exp_w) begin
                    miscompares++;
                    $display("FAIL stream_word: got %h, want %h", dump_data, exp_w);
                end
            end
        end
        if (rst_b && ram_cs && !eng_rd && !eng_wr) dump_reads++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic start_dump(input logic [9:0] a, input logic [9:0] l);
        for (int i = 0; i <= int'(l); i++) exp_q.push_back(pat(a + 10'(i)));
        dump_addr  = a;
        dump_len   = l;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_b = 1'b0; eng_rd = 1'b1; eng_wr = 1'b0; eng_addr = 10'h005; eng_d4wt = '0;
        dump_start = 1'b0; dump_addr = '0; dump_len = '0; dump_ready = 1'b1;
        #2;
        vectors++;
        if (dump_busy !== 1'b0 || dump_valid !== 1'b0 || dump_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%0d valid=%0d data=%h, want 0/0/0",
                     dump_busy, dump_valid, dump_data);
        end
        vectors++;
        if (ram_cs !== 1'b1 || ram_addr !== 10'h005) begin
            miscompares++;
            $display("FAIL reset_ram_follow: cs=%0d addr=%h, want 1/005", ram_cs, ram_addr);
        end
        eng_rd = 1'b0;
        repeat (3) step();
        rst_b = 1'b1;
        step();
        vectors++;
        if (dump_busy !== 1'b0 || dump_valid !== 1'b0 || ram_cs !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: busy=%0d valid=%0d cs=%0d, want 0/0/0",
                     dump_busy, dump_valid, ram_cs);
        end
    endtask

    task automatic test_engine();
        step();
        eng_rd = 1'b1; eng_addr = 10'h155;
        sample();
        vectors++;
        if (ram_cs !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 10'h155) begin
            miscompares++;
            $display("FAIL eng_read_req: cs=%0d we=%0d addr=%h, want 1/0/155", ram_cs, ram_we, ram_addr);
        end
        step();
        eng_rd = 1'b0;
        sample();
        vectors++;
        if (eng_d4rd !== pat(10'h155)) begin
            miscompares++;
            $display("FAIL eng_read_data: got %h, want %h", eng_d4rd, pat(10'h155));
        end
        step();
        eng_rd = 1'b1; eng_wr = 1'b1; eng_addr = 10'h2AA; eng_d4wt = 32'h1234_5678;
        sample();
        vectors++;
        if (ram_cs !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 10'h2AA || ram_wdata !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL eng_write_wins: cs=%0d we=%0d addr=%h wdata=%h, want 1/1/2aa/12345678",
                     ram_cs, ram_we, ram_addr, ram_wdata);
        end
        step();
        eng_wr = 1'b0;
        step();
        eng_rd = 1'b0;
        sample();
        vectors++;
        if (eng_d4rd !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL eng_readback: got %h, want 12345678", eng_d4rd);
        end
        step();
        eng_wr = 1'b1; eng_d4wt = pat(10'h2AA);
        step();
        eng_wr = 1'b0;
    endtask

    task automatic test_basic_dump();
        int c;
        step();
        start_dump(10'h010, 10'd3);
        sample();
        vectors++;
        if (dump_busy !== 1'b1 || dump_valid !== 1'b0 || ram_cs !== 1'b1 || ram_addr !== 10'h010) begin
            miscompares++;
            $display("FAIL basic_first_read: busy=%0d valid=%0d cs=%0d addr=%h, want 1/0/1/010",
                     dump_busy, dump_valid, ram_cs, ram_addr);
        end
        sample();
        vectors++;
        if (dump_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_latency_early: valid=%0d at cycle 2, want 0", dump_valid);
        end
        for (int k = 0; k < 4; k++) begin
            sample();
            vectors++;
            if (dump_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL basic_throughput: valid=%0d at cycle %0d, want 1", dump_valid, k + 3);
            end
        end
        sample();
        vectors++;
        if (dump_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_tail: valid=%0d after last word, want 0", dump_valid);
        end
        c = 0;
        while (dump_busy && c < 6) begin sample(); c++; end
        vectors++;
        if (dump_busy !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL basic_done: busy=%0d pending=%0d, want 0/0", dump_busy, exp_q.size());
        end
    endtask

    task automatic test_collision();
        int c;
        step();
        start_dump(10'h040, 10'd3);
        step();
        eng_rd = 1'b1; eng_addr = 10'h300;
        sample();
        vectors++;
        if (ram_cs !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 10'h300) begin
            miscompares++;
            $display("FAIL coll_engine_owns: cs=%0d we=%0d addr=%h, want 1/0/300", ram_cs, ram_we, ram_addr);
        end
        step();
        eng_rd = 1'b0;
        sample();
        vectors++;
        if (ram_cs !== 1'b1 || ram_addr !== 10'h041 || eng_d4rd !== pat(10'h300)) begin
            miscompares++;
            $display("FAIL coll_slip: cs=%0d addr=%h d4rd=%h, want 1/041/%h",
                     ram_cs, ram_addr, eng_d4rd, pat(10'h300));
        end
        c = 0;
        while ((dump_busy || exp_q.size() != 0) && c < 40) begin sample(); c++; end
        vectors++;
        if (dump_busy !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL coll_done: busy=%0d pending=%0d, want 0/0", dump_busy, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int c, w0;
        step();
        w0 = words_rx;
        start_dump(10'h100, 10'd9);
        repeat (3) step();
        dump_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            sample();
            vectors++;
            if (dump_reads - words_rx - (1024 - 1024) > 2 + (dump_reads - dump_reads)) begin
                miscompares++;
                $display("FAIL bp_buffered: outstanding=%0d, want <= 2", dump_reads - words_rx);
            end
            if (k >= 2) begin
                vectors++;
                if (ram_cs !== 1'b0 || dump_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL bp_stall: cs=%0d valid=%0d, want 0/1", ram_cs, dump_valid);
                end
            end
            step();
        end
        dump_ready = 1'b1;
        c = 0;
        while ((dump_busy || exp_q.size() != 0) && c < 60) begin sample(); c++; end
        vectors++;
        if (dump_busy !== 1'b0 || exp_q.size() != 0 || words_rx - w0 != 10) begin
            miscompares++;
            $display("FAIL bp_done: busy=%0d pending=%0d words=%0d, want 0/0/10",
                     dump_busy, exp_q.size(), words_rx - w0);
        end
    endtask

    task automatic test_wrap();
        int c, w0;
        step();
        w0 = words_rx;
        start_dump(10'h3FE, 10'd3);
        sample();
        vectors++;
        if (ram_addr !== 10'h3FE) begin
            miscompares++;
            $display("FAIL wrap_first_addr: got %h, want 3fe", ram_addr);
        end
        c = 0;
        while ((dump_busy || exp_q.size() != 0) && c < 40) begin sample(); c++; end
        vectors++;
        if (dump_busy !== 1'b0 || exp_q.size() != 0 || words_rx - w0 != 4) begin
            miscompares++;
            $display("FAIL wrap_done: busy=%0d pending=%0d words=%0d, want 0/0/4",
                     dump_busy, exp_q.size(), words_rx - w0);
        end
    endtask

    task automatic test_full_length();
        int c, w0, r0;
        step();
        w0 = words_rx;
        r0 = dump_reads;
        start_dump(10'h123, 10'h3FF);
        c = 0;
        while ((dump_busy || exp_q.size() != 0) && c < 8000) begin
            dump_ready = ($urandom_range(3) != 0);
            eng_rd     = ($urandom_range(3) == 0);
            eng_addr   = 10'($urandom_range(1023));
            step();
            c++;
        end
        dump_ready = 1'b1;
        eng_rd     = 1'b0;
        vectors++;
        if (dump_busy !== 1'b0 || exp_q.size() != 0 || words_rx - w0 != 1024 || dump_reads - r0 != 1024) begin
            miscompares++;
            $display("FAIL full_len: busy=%0d pending=%0d words=%0d reads=%0d, want 0/0/1024/1024",
                     dump_busy, exp_q.size(), words_rx - w0, dump_reads - r0);
        end
    endtask

    task automatic test_reset_mid();
        int c, w0;
        step();
        start_dump(10'h200, 10'd20);
        repeat (2) step();
        rst_b = 1'b0;
        #1;
        vectors++;
        if (dump_busy !== 1'b0 || dump_valid !== 1'b0 || ram_cs !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_abort: busy=%0d valid=%0d cs=%0d, want 0/0/0",
                     dump_busy, dump_valid, ram_cs);
        end
        exp_q.delete();
        repeat (2) step();
        rst_b = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sample();
            vectors++;
            if (dump_busy !== 1'b0 || dump_valid !== 1'b0 || ram_cs !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_mid_quiet: busy=%0d valid=%0d cs=%0d, want 0/0/0",
                         dump_busy, dump_valid, ram_cs);
            end
            step();
        end
        w0 = words_rx;
        start_dump(10'h050, 10'd2);
        c = 0;
        while ((dump_busy || exp_q.size() != 0) && c < 40) begin sample(); c++; end
        vectors++;
        if (dump_busy !== 1'b0 || exp_q.size() != 0 || words_rx - w0 != 3) begin
            miscompares++;
            $display("FAIL rst_mid_restart: busy=%0d pending=%0d words=%0d, want 0/0/3",
                     dump_busy, exp_q.size(), words_rx - w0);
        end
    endtask

    task automatic test_start_while_busy();
        int c, w0;
        step();
        w0 = words_rx;
        start_dump(10'h080, 10'd5);
        step();
        dump_addr  = 10'h200;
        dump_len   = 10'd1;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        c = 0;
        while ((dump_busy || exp_q.size() != 0) && c < 40) begin sample(); c++; end
        vectors++;
        if (dump_busy !== 1'b0 || exp_q.size() != 0 || words_rx - w0 != 6) begin
            miscompares++;
            $display("FAIL busy_start_ignored: busy=%0d pending=%0d words=%0d, want 0/0/6",
                     dump_busy, exp_q.size(), words_rx - w0);
        end
    endtask

    initial begin
        test_reset();
        test_engine();
        test_basic_dump();
        test_collision();
        test_backpressure();
        test_wrap();
        test_full_length();
        test_reset_mid();
        test_start_while_busy();
        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
